// File: rtl/pending_serve32.sv
// Pending-request bitmap with a single registered output slot that serves
// the highest-index pending request, with a valid/ready handshake.
module pending_serve32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] set_bits,
  input  logic        clear_all,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] pending,
  output logic [5:0]  pending_cnt,
  output logic        overflow
);

  localparam int unsigned N      = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = 6;

  logic [N-1:0]     pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             overflow_q, overflow_d;

  logic             fire;
  logic             reload;
  logic [N-1:0]     served_mask;
  logic [N-1:0]     candidate;
  logic [N-1:0]     pending_next;
  logic             cand_any;
  logic [IDX_W-1:0] cand_idx;

  // Handshake and next pending vector; a fresh set wins over the served clear.
  always_comb begin
    fire         = out_valid_q & out_ready;
    served_mask  = fire ? (N'(1) << out_index_q) : '0;
    candidate    = pending_q & ~served_mask;
    pending_next = candidate | set_bits;
    reload       = ~out_valid_q | fire;
  end

  // Highest-index set bit of the candidate; later iterations override earlier ones.
  always_comb begin
    cand_any = 1'b0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (candidate[i]) begin
        cand_any = 1'b1;
        cand_idx = IDX_W'(i);
      end
    end
  end

  // Next-state for pending, count, output slot and sticky overflow.
  always_comb begin
    pending_d   = pending_next;
    cnt_d       = '0;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    overflow_d  = overflow_q | (|(set_bits & pending_q & ~served_mask));

    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + CNT_W'(pending_next[i]);
    end

    if (reload) begin
      out_valid_d = cand_any;
      if (cand_any) begin
        out_index_d = cand_idx;
      end
    end

    // Flush retracts the presentation without a handshake; out_index is left as is.
    if (clear_all) begin
      pending_d   = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pending     = pending_q;
  assign pending_cnt = cnt_q;
  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/pending_serve32.md
PENDING_SERVE32 -- requirements
Module: pending_serve32

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port set_bits, input, 32, one-cycle request pulses; bit i marks request i pending.
REQ-004 SHALL have port clear_all, input, 1, synchronous flush of all pending state.
REQ-005 SHALL have port out_valid, output, 1, out_index holds a served request.
REQ-006 SHALL have port out_ready, input, 1, consumer accepts out_index when high with out_valid.
REQ-007 SHALL have port out_index, output, 5, index of the presented request.
REQ-008 SHALL have port pending, output, 32, registered pending vector.
REQ-009 SHALL have port pending_cnt, output, 6, registered popcount of pending (0..32).
REQ-010 SHALL have port overflow, output, 1, sticky flag for a request arriving on an already-pending bit.

Function
REQ-011 SHALL define fire = out_valid & out_ready, and served_mask = one-hot(out_index) when fire, else 0.
REQ-012 SHALL update pending_next = (pending & ~served_mask) | set_bits; set_bits wins over served clear for the same bit in the same cycle.
REQ-013 SHALL reload the output slot when out_valid==0 or fire; it SHALL hold out_valid and out_index stable while out_valid & ~out_ready, even if higher-index bits arrive.
REQ-014 SHALL, on reload, use candidate = pending & ~served_mask (current registered pending, not pending_next).
REQ-015 SHALL, on reload, set out_valid = (candidate != 0) and out_index = highest set bit index of candidate; bit 31 has highest priority, bit 0 lowest.
REQ-016 SHALL leave out_index unchanged when reload yields out_valid=0.
REQ-017 SHALL present a new request with latency 2: set_bits at edge N, pending at N+1, out_valid at N+2, when the slot is free.
REQ-018 SHALL sustain one served index per cycle while out_ready is held high and candidates exist.
REQ-019 SHALL never present the same pending entry twice; a served bit re-set in the fire cycle is presented again only after it reappears in pending.
REQ-020 SHALL set overflow when any set_bits[i]=1 while pending[i]=1 and served_mask[i]=0; it SHALL remain set until clear_all or rst.
REQ-021 SHALL compute pending_cnt as popcount(pending_next), registered together with pending.
REQ-022 SHALL, on clear_all, set pending=0, pending_cnt=0, out_valid=0, overflow=0 at the next edge; clear_all overrides set_bits and a simultaneous fire.
REQ-023 SHALL drop out_valid on clear_all without a handshake; consumer must treat this as a retracted request.

Reset
REQ-024 SHALL, on rst, drive pending=0, pending_cnt=0, out_valid=0, out_index=0, overflow=0 at the next edge.
REQ-025 SHALL give rst priority over clear_all, set_bits and out_ready.
REQ-026 SHALL discard any in-flight presentation when rst is asserted mid-operation.

Verification
REQ-027 Single request: set_bits=0x0000_0100 one cycle, out_ready=1 -> pending=0x100, cnt=1 at +1; out_valid=1, out_index=8 at +2; pending=0, out_valid=0 at +3.
REQ-028 Priority drain: set_bits=0x8000_0005, out_ready=1 -> out_index sequence 31, 2, 0 on consecutive cycles; then out_valid=0, cnt=0.
REQ-029 Backpressure hold: set bit 3, out_ready=0 until out_valid; then set bit 20 -> out_index stays 3 until out_ready=1; next presented index=20.
REQ-030 Overflow and race: bit 5 pending and presented, set_bits bit 5 during fire -> overflow stays 0, bit 5 re-presented later; set bit 7 twice while pending -> overflow=1.
REQ-031 Flush: pending=0xFFFF_FFFF, cnt=32, out_valid=1, clear_all=1 with set_bits=0x1 -> pending=0, cnt=0, out_valid=0, overflow=0 next cycle.
REQ-032 Reset mid-drain: rst during back-to-back serving of 0xF0 -> all outputs zero next edge, no further out_valid until new set_bits.
